// File: rtl/mult_seq_if.sv
// mult_seq_if: start/busy multiply handshake between a requester and the mult_seq responder.
interface mult_seq_if #(parameter int WIDTH = 8);
  logic               start_i;
  logic [WIDTH-1:0]   a_bi;
  logic [WIDTH-1:0]   b_bi;
  logic               busy_o;
  logic               done_o;
  logic [2*WIDTH-1:0] y_bo;
  modport master (output start_i, a_bi, b_bi, input busy_o, done_o, y_bo);
  modport slave  (input start_i, a_bi, b_bi, output busy_o, done_o, y_bo);
endinterface

// File: rtl/mult_seq.sv
// mult_seq: unsigned shift-and-add multiplier, one multiplier bit per clock, LSB first.
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  mult_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, WORK} state_t;
  state_t             state;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] acc, acc_nx, y_r;
  logic [CW-1:0]      ctr;
  logic               done_r, b_bit;
  assign b_bit  = |(b_r & (WIDTH'(1) << ctr));
  assign acc_nx = acc + ({{WIDTH{1'b0}}, a_r & {WIDTH{b_bit}}} << ctr);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      ctr    <= '0;
      y_r    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start_i) begin
          a_r   <= bus.a_bi;
          b_r   <= bus.b_bi;
          acc   <= '0;
          ctr   <= '0;
          state <= WORK;
        end
      end else begin
        acc <= acc_nx;
        ctr <= ctr + CW'(1);
        if (ctr == CW'(WIDTH - 1)) begin
          y_r    <= acc_nx;
          done_r <= 1'b1;
          state  <= IDLE;
        end
      end
    end
  assign bus.busy_o = (state == WORK);
  assign bus.done_o = done_r;
  assign bus.y_bo   = y_r;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: randomized and directed checks of mult_seq against a plain a*b reference.
module tb_mult_seq;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  mult_seq_if #(.WIDTH(W)) m();
  mult_seq #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(m));
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                       output logic [2*W-1:0] y, output logic [2*W-1:0] y0,
                       output int lat, output int ovl, output int bh);
    m.start_i = 1'b1;
    m.a_bi = a;
    m.b_bi = b;
    step();
    if (!hold) m.start_i = 1'b0;
    m.a_bi = W'($urandom);
    m.b_bi = W'($urandom);
    y0 = m.y_bo;
    lat = 0;
    ovl = 0;
    bh = int'(m.busy_o);
    while (m.done_o !== 1'b1 && lat < 4*W) begin
      step();
      lat++;
      bh += int'(m.busy_o);
      if (m.done_o && m.busy_o) ovl++;
    end
    y = m.y_bo;
  endtask

  task automatic test_reset();
    m.start_i = 1'b1;
    m.a_bi = 8'hAA;
    m.b_bi = 8'h55;
    rst = 1'b1;
    repeat (2) step();
    total++; if (m.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", m.busy_o); end
    total++; if (m.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", m.done_o); end
    total++; if (m.y_bo !== '0) begin bad++; $display("FAIL reset_y got %h want 0", m.y_bo); end
    m.start_i = 1'b0;
    #2 rst = 1'b0;
    step();
    total++; if (m.busy_o !== 1'b0) begin bad++; $display("FAIL reset_start_ignored busy got %b want 0", m.busy_o); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] ta [3] = '{8'hFF, 8'h00, 8'h01};
    logic [W-1:0] tb [3] = '{8'hFF, 8'hA5, 8'h80};
    logic [2*W-1:0] te [3] = '{16'hFE01, 16'h0000, 16'h0080};
    logic [2*W-1:0] y, y0;
    int lat, ovl, bh;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], 1'b0, y, y0, lat, ovl, bh);
      total++; if (y !== te[i]) begin bad++; $display("FAIL vec%0d_y got %h want %h", i, y, te[i]); end
      total++; if (lat != W) begin bad++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, W); end
      total++; if (bh != W) begin bad++; $display("FAIL vec%0d_busy_cycles got %0d want %0d", i, bh, W); end
      total++; if (ovl != 0) begin bad++; $display("FAIL vec%0d_done_with_busy got %0d want 0", i, ovl); end
      step();
      total++; if (m.done_o !== 1'b0) begin bad++; $display("FAIL vec%0d_done_pulse got %b want 0", i, m.done_o); end
    end
  endtask

  task automatic test_ignore_start();
    int n, dn, bz;
    m.start_i = 1'b1;
    m.a_bi = 8'd3;
    m.b_bi = 8'd5;
    step();
    m.start_i = 1'b0;
    repeat (2) step();
    m.a_bi = 8'h7F;
    m.b_bi = 8'h7F;
    m.start_i = 1'b1;
    step();
    m.start_i = 1'b0;
    n = 3;
    while (m.done_o !== 1'b1 && n < 4*W) begin step(); n++; end
    total++; if (n != W) begin bad++; $display("FAIL ign_latency got %0d want %0d", n, W); end
    total++; if (m.y_bo !== 16'h000F) begin bad++; $display("FAIL ign_y got %h want 000f", m.y_bo); end
    dn = 0;
    bz = 0;
    repeat (2*W) begin step(); dn += int'(m.done_o); bz += int'(m.busy_o); end
    total++; if (dn != 0 || bz != 0) begin bad++; $display("FAIL ign_second_op got done=%0d busy=%0d want 0/0", dn, bz); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] y, y0;
    int lat, ovl, bh, n;
    do_op(8'd7, 8'd9, 1'b1, y, y0, lat, ovl, bh);
    total++; if (y !== 16'h003F) begin bad++; $display("FAIL b2b_y1 got %h want 003f", y); end
    total++; if (lat != W) begin bad++; $display("FAIL b2b_latency1 got %0d want %0d", lat, W); end
    total++; if (m.busy_o !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap busy got %b want 0", m.busy_o); end
    m.a_bi = 8'd2;
    m.b_bi = 8'd3;
    step();
    m.start_i = 1'b0;
    total++; if (m.busy_o !== 1'b1) begin bad++; $display("FAIL b2b_reaccept busy got %b want 1", m.busy_o); end
    n = 0;
    while (m.done_o !== 1'b1 && n < 4*W) begin step(); n++; end
    total++; if (n != W || m.y_bo !== 16'h0006) begin bad++; $display("FAIL b2b_op2 got y=%h lat=%0d want 0006/%0d", m.y_bo, n, W); end
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] y, y0;
    int lat, ovl, bh, dn, ynz;
    m.start_i = 1'b1;
    m.a_bi = 8'h12;
    m.b_bi = 8'h34;
    step();
    m.start_i = 1'b0;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    total++; if (m.busy_o !== 1'b0) begin bad++; $display("FAIL arst_busy got %b want 0", m.busy_o); end
    total++; if (m.done_o !== 1'b0) begin bad++; $display("FAIL arst_done got %b want 0", m.done_o); end
    total++; if (m.y_bo !== '0) begin bad++; $display("FAIL arst_y got %h want 0", m.y_bo); end
    step();
    #2 rst = 1'b0;
    dn = 0;
    ynz = 0;
    repeat (2*W) begin step(); dn += int'(m.done_o); ynz += int'(m.y_bo != '0); end
    total++; if (dn != 0 || ynz != 0) begin bad++; $display("FAIL arst_aborted got done=%0d ynz=%0d want 0/0", dn, ynz); end
    do_op(8'h12, 8'h34, 1'b0, y, y0, lat, ovl, bh);
    total++; if (y !== ref_mul(8'h12, 8'h34) || lat != W) begin bad++; $display("FAIL arst_restart got y=%h lat=%0d want %h/%0d", y, lat, ref_mul(8'h12, 8'h34), W); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [2*W-1:0] y, y0, exp, prev;
    int lat, ovl, bh;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      exp = ref_mul(a, b);
      prev = m.y_bo;
      do_op(a, b, 1'b0, y, y0, lat, ovl, bh);
      total++; if (y !== exp) begin bad++; $display("FAIL rnd%0d_y a=%h b=%h got %h want %h", i, a, b, y, exp); end
      total++; if (lat != W) begin bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, W); end
      total++; if (y0 !== prev) begin bad++; $display("FAIL rnd%0d_y_on_accept got %h want %h", i, y0, prev); end
      total++; if (ovl != 0) begin bad++; $display("FAIL rnd%0d_done_with_busy got %0d want 0", i, ovl); end
      if ($urandom_range(3) == 0) step();
    end
  endtask

  initial begin
    m.start_i = 1'b0;
    m.a_bi = '0;
    m.b_bi = '0;
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; result width is 2*WIDTH.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 start_i  input  1  request to start a multiplication; sampled on the rising clk_i edge.
REQ-005 a_bi  input  WIDTH  unsigned multiplicand; captured when start_i is accepted.
REQ-006 b_bi  input  WIDTH  unsigned multiplier; captured when start_i is accepted.
REQ-007 busy_o  output  1  high while a multiplication is in progress.
REQ-008 done_o  output  1  one-cycle pulse when y_bo has been updated with a new product.
REQ-009 y_bo  output  2*WIDTH  unsigned product of the last completed operation, held until the next completion.

Function
REQ-010 Block SHALL be the responder side of the start/busy multiply handshake: the requester raises start_i, waits for busy_o low, then reads y_bo.
REQ-011 FSM SHALL have exactly two states, IDLE and WORK; busy_o SHALL equal (state == WORK), decoded from the registered state only.
REQ-012 In IDLE with start_i=1 at an edge: capture a_bi, b_bi; clear accumulator; clear bit counter; go to WORK.
REQ-013 In IDLE with start_i=0: remain in IDLE; internal registers and y_bo unchanged.
REQ-014 In WORK, each edge SHALL process one multiplier bit, LSB first: accumulator += (captured a AND replicated b[ctr]) shifted left by ctr; ctr increments by 1.
REQ-015 The edge processing bit WIDTH-1 SHALL load the final accumulator value into y_bo, drive done_o=1 for that one cycle, and return to IDLE.
REQ-016 Latency: start accepted at edge N -> busy_o high from edge N through edge N+WIDTH; y_bo valid and done_o high after edge N+WIDTH (8 cycles for WIDTH=8).
REQ-017 done_o SHALL be 0 in every cycle except the one following completion; it SHALL never be high together with busy_o.
REQ-018 start_i SHALL be ignored while in WORK, including on the final WORK edge; a new request is accepted only in IDLE, so back-to-back operations have one IDLE cycle minimum between them.
REQ-019 Changes on a_bi/b_bi while in WORK SHALL not affect the running product.
REQ-020 Arithmetic SHALL be unsigned and exact; accumulator is 2*WIDTH bits and cannot overflow.
REQ-021 y_bo SHALL not change when a new start is accepted; it changes only at completion or reset.
REQ-022 Bit counter SHALL be ceil(log2(WIDTH))+1 bits wide or wider so it cannot wrap before WIDTH iterations.

Reset
REQ-023 While rst_i=1, independent of clk_i: state=IDLE, busy_o=0, done_o=0, y_bo=0, accumulator, captured operands and counter = 0.
REQ-024 Reset asserted during WORK SHALL abort the operation with no done_o pulse; y_bo reads 0 afterwards.
REQ-025 After rst_i deasserts, the first edge with start_i=1 SHALL be accepted normally.
REQ-026 start_i high at the edge where rst_i is still asserted SHALL be ignored.

Verification
REQ-027 a=0xFF, b=0xFF, start pulse -> busy_o high 8 cycles, then y_bo=0xFE01, done_o single pulse.
REQ-028 a=0x00, b=0xA5 -> y_bo=0x0000 after 8 cycles; a=0x01, b=0x80 -> y_bo=0x0080.
REQ-029 a=3, b=5 started; change a_bi=0x7F, b_bi=0x7F and pulse start_i at cycle 3 -> y_bo=0x000F, single done_o, no second operation.
REQ-030 Back-to-back: 7*9 then start held high through done -> y_bo=0x003F, then next op accepted on first IDLE edge, busy_o low exactly one cycle.
REQ-031 a=0x12, b=0x34 started; assert rst_i asynchronously at cycle 4 -> busy_o, done_o, y_bo drop to 0 immediately; no done_o pulse.
REQ-032 Randomized 1000 operand pairs against a reference model -> every y_bo equals a*b, every done_o exactly WIDTH cycles after its accepted start.
